// File: rtl/alu_pkg.sv
// Shared types and constants for the serial ALU and its stimulus driver.
package alu_pkg;

    // ALU opcodes carried in the control frame.
    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } alu_op_t;

    // Error-injection modes of the serial driver.
    typedef enum logic [1:0] {
        GOOD     = 2'b00,
        BAD_CRC  = 2'b01,
        BAD_DATA = 2'b10,
        BAD_OP   = 2'b11
    } inj_mode_t;

    // Driver FSM states.
    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_CRC_CALC = 2'b01,
        S_SEND     = 2'b10
    } drv_state_t;

    localparam logic [2:0] BAD_OP_CODE = 3'b010;
    localparam int         FRAME_BITS  = 11;
    localparam logic [3:0] CRC4_POLY   = 4'b0011;

    // One step of the x^4+x+1 LFSR, feeding data bit d.
    function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic d);
        logic fb;
        fb = crc[3] ^ d;
        return {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
    endfunction

endpackage

// File: rtl/alu_crc4_serial.sv
// Bit-serial CRC4 (x^4+x+1, init 0). Shared by the driver and a future checker.
module alu_crc4_serial
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic       d,
    output logic [3:0] crc
);

    // Clear has priority over a shift so a new message always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 4'b0000;
        end else if (clear) begin
            crc <= 4'b0000;
        end else if (en) begin
            crc <= crc4_step(crc, d);
        end
    end

endmodule

// File: rtl/alu_serial_driver.sv
// Serial frame generator for the ALU input line: accepts one request, computes
// its CRC4 one bit per clock, then streams data frames and a control frame.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE; req_valid is ignored at every other time.
module alu_serial_driver
    import alu_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int BIT_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [8*DATA_BYTES-1:0] a_in,
    input  logic [8*DATA_BYTES-1:0] b_in,
    input  logic [2:0]              op_in,
    input  logic [1:0]              mode_in,
    output logic                    sin,
    output logic                    busy,
    output logic                    done
);

    localparam int W      = 8 * DATA_BYTES;
    localparam int N      = 2 * W + 4;
    localparam int NBYTES = 2 * DATA_BYTES;
    localparam int CNT_W  = $clog2(N);
    localparam int BYTE_W = $clog2(NBYTES + 1);
    localparam int DIV_W  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    drv_state_t        state_q, state_d;
    logic [W-1:0]      a_q, b_q;
    logic [2:0]        op_q;
    inj_mode_t         mode_q;
    logic [CNT_W-1:0]  calc_cnt;
    logic [3:0]        bit_idx;
    logic [BYTE_W-1:0] byte_idx;
    logic [DIV_W-1:0]  div_cnt;
    logic              tail_q;
    logic              sin_q;
    logic              done_q;

    logic              accept;
    logic [N-1:0]      stream;
    logic              calc_last;
    logic [3:0]        crc;
    logic [3:0]        crc_field;
    logic [BYTE_W-1:0] last_frame;
    logic              is_ctrl;
    logic [7:0]        sel_byte;
    logic [10:0]       frame_word;
    logic              cur_bit;
    logic              div_end;
    logic              bit_end;

    assign accept    = req_valid && (state_q == S_IDLE);
    assign stream    = {b_q, a_q, 1'b1, op_q};
    assign calc_last = (calc_cnt == CNT_W'(N - 1));

    alu_crc4_serial u_crc (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (state_q == S_CRC_CALC),
        .d     (stream[CNT_W'(N - 1) - calc_cnt]),
        .crc   (crc)
    );

    // Current frame contents and the bit to put on the line next.
    always_comb begin
        crc_field  = (mode_q == BAD_CRC) ? crc + 4'd1 : crc;
        last_frame = (mode_q == BAD_DATA) ? BYTE_W'(NBYTES - 1) : BYTE_W'(NBYTES);
        is_ctrl    = (byte_idx == last_frame);
        sel_byte   = 8'(({b_q, a_q} << {byte_idx, 3'b000}) >> (2 * W - 8));
        frame_word = is_ctrl ? {3'b010, op_q, crc_field, 1'b1} : {2'b00, sel_byte, 1'b1};
        cur_bit    = frame_word[4'd10 - bit_idx];
        div_end    = (div_cnt == DIV_W'(BIT_CYCLES - 1));
        bit_end    = (bit_idx == 4'(FRAME_BITS - 1));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = S_CRC_CALC;
            end
            S_CRC_CALC: if (calc_last) state_d = S_SEND;
            S_SEND:     if (tail_q) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Request capture, CRC bit counter, frame counters and the registered line.
    // tail_q marks the extra cycle after the last stop bit in which done fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'b000;
            mode_q   <= GOOD;
            calc_cnt <= '0;
            bit_idx  <= 4'd0;
            byte_idx <= '0;
            div_cnt  <= '0;
            tail_q   <= 1'b0;
            sin_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    sin_q <= 1'b1;
                    if (req_valid) begin
                        a_q      <= a_in;
                        b_q      <= b_in;
                        mode_q   <= inj_mode_t'(mode_in);
                        op_q     <= (inj_mode_t'(mode_in) == BAD_OP) ? BAD_OP_CODE : op_in;
                        calc_cnt <= '0;
                    end
                end
                S_CRC_CALC: calc_cnt <= calc_last ? '0 : calc_cnt + CNT_W'(1);
                S_SEND: begin
                    if (tail_q) begin
                        sin_q  <= 1'b1;
                        done_q <= 1'b1;
                        tail_q <= 1'b0;
                    end else begin
                        if (div_cnt == '0) sin_q <= cur_bit;
                        if (div_end) begin
                            div_cnt <= '0;
                            if (bit_end) begin
                                bit_idx <= 4'd0;
                                if (is_ctrl) begin
                                    byte_idx <= '0;
                                    tail_q   <= 1'b1;
                                end else begin
                                    byte_idx <= byte_idx + BYTE_W'(1);
                                end
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sin  = sin_q;
    assign done = done_q;
    assign busy = !req_ready;

endmodule

// File: tb/tb_alu_serial_driver.sv
// Bench for alu_serial_driver: two instances (4 bytes / 1 clk per bit and
// 2 bytes / 4 clks per bit), expected frames and done edges queued at issue.
module tb_alu_serial_driver;
    import alu_pkg::*;

    localparam int N0  = 68;
    localparam int N1  = 36;
    localparam int BC1 = 4;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        v0 = 1'b0, rdy0, sin0, busy0, done0;
    logic [31:0] a0 = '0, b0 = '0;
    logic [2:0]  op0 = '0;
    logic [1:0]  m0 = '0;
    logic        v1 = 1'b0, rdy1, sin1, busy1, done1;
    logic [15:0] a1 = '0, b1 = '0;
    logic [2:0]  op1 = '0;
    logic [1:0]  m1 = '0;

    alu_serial_driver #(.DATA_BYTES(4), .BIT_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .a_in(a0), .b_in(b0),
        .op_in(op0), .mode_in(m0), .sin(sin0), .busy(busy0), .done(done0));

    alu_serial_driver #(.DATA_BYTES(2), .BIT_CYCLES(BC1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .a_in(a1), .b_in(b1),
        .op_in(op1), .mode_in(m1), .sin(sin1), .busy(busy1), .done(done1));

    // Scoreboard state
    int errors = 0;
    int checks = 0;
    logic [10:0] exp_q0[$], exp_q1[$];
    int done_q0[$], done_q1[$];
    int acc0 = 0, acc1 = 0;
    bit first0 = 1'b0, first1 = 1'b0;
    int ndone0 = 0, ndone1 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic get_sin(input int inst);
        return (inst == 0) ? sin0 : sin1;
    endfunction

    function automatic logic get_rdy(input int inst);
        return (inst == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic [10:0] dframe(input logic [7:0] d);
        return {2'b00, d, 1'b1};
    endfunction

    function automatic logic [10:0] cframe(input logic [2:0] op, input logic [3:0] crc);
        return {3'b010, op, crc, 1'b1};
    endfunction

    // Reference CRC4: x^4+x+1, init 0, over {B, A, 1, op} MSB first
    function automatic logic [3:0] crc_bit(input logic [3:0] c, input logic d);
        logic fb;
        fb = c[3] ^ d;
        return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    function automatic logic [3:0] crc_ref(input logic [31:0] a, input logic [31:0] b,
                                          input int db, input logic [2:0] op);
        logic [3:0] c;
        c = 4'b0000;
        for (int i = 8 * db - 1; i >= 0; i--) c = crc_bit(c, b[i]);
        for (int i = 8 * db - 1; i >= 0; i--) c = crc_bit(c, a[i]);
        c = crc_bit(c, 1'b1);
        for (int i = 2; i >= 0; i--) c = crc_bit(c, op[i]);
        return c;
    endfunction

    task automatic push_exp(input int inst, input logic [10:0] w);
        if (inst == 0) exp_q0.push_back(w);
        else           exp_q1.push_back(w);
    endtask

    // Full expected frame list for a request
    task automatic push_model(input int inst, input logic [31:0] a, input logic [31:0] b,
                              input int db, input logic [2:0] op, input logic [1:0] mode);
        logic [2:0] eop;
        logic [3:0] c;
        eop = (mode == 2'b11) ? 3'b010 : op;
        c   = crc_ref(a, b, db, eop);
        if (mode == 2'b01) c = c + 4'd1;
        for (int i = db - 1; i >= 0; i--) push_exp(inst, dframe(b[8*i +: 8]));
        for (int i = db - 1; i >= 0; i--)
            if (!(mode == 2'b10 && i == 0)) push_exp(inst, dframe(a[8*i +: 8]));
        push_exp(inst, cframe(eop, c));
    endtask

    // Driver: wait for ready, present one request for one edge
    task automatic send(input int inst, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [1:0] mode,
                        input bit expect_done, input int lat);
        int t;
        t = 0;
        @(negedge clk);
        while (get_rdy(inst) !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", 64'(t < 2000), 64'd1);
        if (inst == 0) begin
            v0 = 1'b1; a0 = a; b0 = b; op0 = op; m0 = mode;
            acc0 = cyc + 1; first0 = 1'b1;
            if (expect_done) done_q0.push_back(acc0 + lat);
        end else begin
            v1 = 1'b1; a1 = a[15:0]; b1 = b[15:0]; op1 = op; m1 = mode;
            acc1 = cyc + 1; first1 = 1'b1;
            if (expect_done) done_q1.push_back(acc1 + lat);
        end
        @(negedge clk);
        if (inst == 0) v0 = 1'b0;
        else           v1 = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int target);
        int t;
        t = 0;
        while (((inst == 0) ? ndone0 : ndone1) < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("done_wait", 64'(t < 3000), 64'd1);
    endtask

    // Frame monitor: decode 11-bit frames off the line and compare with the queue
    task automatic frame_mon(input int inst);
        int bc;
        bc = (inst == 0) ? 1 : BC1;
        forever begin
            @(negedge clk);
            if (!rst && get_sin(inst) === 1'b0) begin
                logic [10:0] w;
                logic [10:0] ew;
                bit held;
                bit aborted;
                bit have;
                held = 1'b1; aborted = 1'b0; have = 1'b1; w = '0; ew = '0;
                if (inst == 0 && first0) begin
                    check("first_low_0", 64'(cyc - acc0), 64'(N0 + 1));
                    first0 = 1'b0;
                end
                if (inst == 1 && first1) begin
                    check("first_low_1", 64'(cyc - acc1), 64'(N1 + 1));
                    first1 = 1'b0;
                end
                for (int k = 0; k < 11; k++) begin
                    for (int j = 0; j < bc; j++) begin
                        if (!(k == 0 && j == 0)) @(negedge clk);
                        if (rst) aborted = 1'b1;
                        if (j == 0) w[10-k] = get_sin(inst);
                        else if (get_sin(inst) !== w[10-k]) held = 1'b0;
                    end
                end
                if (!aborted) begin
                    if (inst == 0) begin
                        if (exp_q0.size() > 0) ew = exp_q0.pop_front();
                        else have = 1'b0;
                    end else begin
                        if (exp_q1.size() > 0) ew = exp_q1.pop_front();
                        else have = 1'b0;
                    end
                    if (!have) begin
                        checks++;
                        errors++;
                        $display("FAIL frame%0d_unexpected: got 0x%0h, expected no frame", inst, w);
                    end else begin
                        check((inst == 0) ? "frame0" : "frame1", 64'(w), 64'(ew));
                    end
                    if (bc > 1) check("bit_hold", 64'(held), 64'd1);
                end
            end
        end
    endtask

    initial frame_mon(0);
    initial frame_mon(1);

    // Done monitor: every pulse must match a queued completion edge
    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            ndone0++;
            if (done_q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done0_unexpected: got pulse at cycle %0d, expected none", cyc);
            end else check("done0_cycle", 64'(cyc), 64'(done_q0.pop_front()));
        end
        if (done1 === 1'b1) begin
            ndone1++;
            if (done_q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done1_unexpected: got pulse at cycle %0d, expected none", cyc);
            end else check("done1_cycle", 64'(cyc), 64'(done_q1.pop_front()));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        int nd;
        int t;

        repeat (2) @(negedge clk);
        check("rst_sin0", 64'(sin0), 64'd1);
        check("rst_ready0", 64'(rdy0), 64'd1);
        check("rst_busy0", 64'(busy0), 64'd0);
        check("rst_done0", 64'(done0), 64'd0);
        check("rst_sin1", 64'(sin1), 64'd1);
        check("rst_ready1", 64'(rdy1), 64'd1);
        @(posedge clk); #2 rst = 1'b0;

        // GOOD, zero operands, AND: CRC 1011, done 168 cycles after acceptance
        for (int i = 0; i < 8; i++) push_exp(0, 11'b00_00000000_1);
        push_exp(0, 11'b010_000_1011_1);
        send(0, 32'h0, 32'h0, OP_AND, GOOD, 1'b1, 168);
        wait_done(0, 1);

        // BAD_CRC, same operands: CRC field 1100, issued right after done
        for (int i = 0; i < 8; i++) push_exp(0, 11'b00_00000000_1);
        push_exp(0, 11'b010_000_1100_1);
        send(0, 32'h0, 32'h0, OP_AND, BAD_CRC, 1'b1, 168);
        wait_done(0, 2);

        // BAD_DATA: last A byte dropped, 7 data frames, done at 157
        push_exp(0, dframe(8'hAA)); push_exp(0, dframe(8'hBB));
        push_exp(0, dframe(8'hCC)); push_exp(0, dframe(8'hDD));
        push_exp(0, dframe(8'h11)); push_exp(0, dframe(8'h22));
        push_exp(0, dframe(8'h33));
        push_exp(0, cframe(3'b100, crc_ref(32'h11223344, 32'hAABBCCDD, 4, 3'b100)));
        send(0, 32'h11223344, 32'hAABBCCDD, OP_ADD, BAD_DATA, 1'b1, 157);
        // A request while busy must be ignored
        repeat (20) @(negedge clk);
        v0 = 1'b1; a0 = 32'h55555555; b0 = 32'h66666666; op0 = OP_OR; m0 = GOOD;
        check("busy_ready_low", 64'(rdy0), 64'd0);
        check("busy_high", 64'(busy0), 64'd1);
        repeat (3) @(negedge clk);
        v0 = 1'b0;
        wait_done(0, 3);

        // BAD_OP, all-ones operands: control op bits 010
        push_model(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4, OP_SUB, BAD_OP);
        send(0, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_SUB, BAD_OP, 1'b1, 168);
        wait_done(0, 4);

        // 2-byte operands, 4 clocks per bit: 5 frames, done at 36+220+1
        push_model(1, 32'h00001234, 32'h0000ABCD, 2, OP_OR, GOOD);
        send(1, 32'h00001234, 32'h0000ABCD, OP_OR, GOOD, 1'b1, 257);
        wait_done(1, 1);

        // Reset in the middle of the fourth data frame
        nd = ndone0;
        push_exp(0, dframe(8'h05)); push_exp(0, dframe(8'h06)); push_exp(0, dframe(8'h07));
        send(0, 32'h01020304, 32'h05060708, OP_ADD, GOOD, 1'b0, 0);
        t = 0;
        while (cyc < acc0 + N0 + 1 + 33 + 5 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("midrst_sin", 64'(sin0), 64'd1);
        check("midrst_ready", 64'(rdy0), 64'd1);
        check("midrst_busy", 64'(busy0), 64'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_frames_seen", 64'(exp_q0.size()), 64'd0);
        check("midrst_no_done", 64'(ndone0), 64'(nd));
        check("midrst_sin_idle", 64'(sin0), 64'd1);

        // Normal transaction after the abort
        push_model(0, 32'h01020304, 32'h05060708, 4, OP_ADD, GOOD);
        send(0, 32'h01020304, 32'h05060708, OP_ADD, GOOD, 1'b1, 168);
        wait_done(0, nd + 1);

        repeat (20) @(negedge clk);
        check("end_sin0", 64'(sin0), 64'd1);
        check("exp_q0_empty", 64'(exp_q0.size()), 64'd0);
        check("exp_q1_empty", 64'(exp_q1.size()), 64'd0);
        check("done_q0_empty", 64'(done_q0.size()), 64'd0);
        check("done_q1_empty", 64'(done_q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
